// File: rtl/fix_checksum_check.sv
// Receive-side FIX checksum verifier: sums each inbound message, parses the
// trailing <SOH>10=ddd<SOH> field and reports one verdict per message.
module fix_checksum_check (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       sop_i,
  output logic       done_o,
  output logic [1:0] err_code_o,
  output logic [7:0] calc_checksum_o,
  output logic [9:0] rcv_value_o
);

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] EQ    = 8'h3D;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_1 = 8'h31;
  localparam logic [7:0] ASC_9 = 8'h39;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_FORMAT   = 2'b10;
  localparam logic [1:0] ERR_ABORT    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_BODY, S_T1, S_T0, S_TEQ, S_D0, S_D1, S_D2, S_TERM
  } state_t;

  state_t     r_state;
  logic [7:0] r_sum;
  logic [7:0] r_snap;
  logic [9:0] r_acc;
  logic       r_done;
  logic [1:0] r_err;
  logic [7:0] r_calc;
  logic [9:0] r_rcv;

  logic [7:0] w_sumNext;
  logic [9:0] w_accNext;
  logic       w_isSoh;
  logic       w_isDigit;

  assign w_sumNext = r_sum + data_i;
  assign w_isSoh   = (data_i == SOH);
  assign w_isDigit = (data_i >= ASC_0) && (data_i <= ASC_9);
  assign w_accNext = (r_acc << 3) + (r_acc << 1) + {2'b00, data_i - ASC_0};

  // Verdict fields always report the snapshot and accumulator as they stood
  // before the deciding byte, which is what makes ABORT show the old message.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sum   <= 8'd0;
      r_snap  <= 8'd0;
      r_acc   <= 10'd0;
      r_done  <= 1'b0;
      r_err   <= ERR_OK;
      r_calc  <= 8'd0;
      r_rcv   <= 10'd0;
    end else begin
      r_done <= 1'b0;
      if (valid_i) begin
        if (sop_i) begin
          if (r_state != S_IDLE) begin
            r_done <= 1'b1;
            r_err  <= ERR_ABORT;
            r_calc <= r_snap;
            r_rcv  <= r_acc;
          end
          r_sum <= data_i;
          if (w_isSoh) begin
            r_snap  <= data_i;
            r_state <= S_T1;
          end else begin
            r_state <= S_BODY;
          end
        end else begin
          case (r_state)
            S_IDLE: begin
            end
            // A partial tag match is still body content, so it is always summed.
            S_BODY, S_T1, S_T0, S_TEQ: begin
              r_sum <= w_sumNext;
              if (w_isSoh) begin
                r_snap  <= w_sumNext;
                r_state <= S_T1;
              end else if (r_state == S_T1 && data_i == ASC_1) begin
                r_state <= S_T0;
              end else if (r_state == S_T0 && data_i == ASC_0) begin
                r_state <= S_TEQ;
              end else if (r_state == S_TEQ && data_i == EQ) begin
                r_acc   <= 10'd0;
                r_state <= S_D0;
              end else begin
                r_state <= S_BODY;
              end
            end
            S_D0, S_D1, S_D2: begin
              if (w_isDigit) begin
                r_acc <= w_accNext;
                case (r_state)
                  S_D0:    r_state <= S_D1;
                  S_D1:    r_state <= S_D2;
                  default: r_state <= S_TERM;
                endcase
              end else begin
                r_done  <= 1'b1;
                r_err   <= ERR_FORMAT;
                r_calc  <= r_snap;
                r_rcv   <= r_acc;
                r_state <= S_IDLE;
              end
            end
            S_TERM: begin
              r_done <= 1'b1;
              r_calc <= r_snap;
              r_rcv  <= r_acc;
              if (!w_isSoh) begin
                r_err <= ERR_FORMAT;
              end else if (r_acc == {2'b00, r_snap}) begin
                r_err <= ERR_OK;
              end else begin
                r_err <= ERR_MISMATCH;
              end
              r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign done_o          = r_done;
  assign err_code_o      = r_err;
  assign calc_checksum_o = r_calc;
  assign rcv_value_o     = r_rcv;

endmodule

// File: tb/tb_fix_checksum_check.sv
// Bench for fix_checksum_check: directed trailer cases plus random messages
// checked against a message-level model ('|' in strings stands for SOH).
module tb_fix_checksum_check;

  localparam logic [7:0] SOH = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       sop_i;
  logic       done_o;
  logic [1:0] err_code_o;
  logic [7:0] calc_checksum_o;
  logic [9:0] rcv_value_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] msgQ[$];

  fix_checksum_check dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .sop_i(sop_i),
    .done_o(done_o),
    .err_code_o(err_code_o),
    .calc_checksum_o(calc_checksum_o),
    .rcv_value_o(rcv_value_o)
  );

  always #5 clk = ~clk;

  task automatic drive_byte(input logic [7:0] b, input logic s);
    data_i = b; valid_i = 1'b1; sop_i = s;
    @(posedge clk); #1;
    valid_i = 1'b0; sop_i = 1'b0;
  endtask

  // Idle cycles carry junk data and a random sop_i that must be ignored.
  task automatic drive_idle();
    data_i = 8'($urandom); sop_i = 1'($urandom_range(0, 1)); valid_i = 1'b0;
    @(posedge clk); #1;
    sop_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; data_i = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_str(input string s);
    msgQ.delete();
    for (int i = 0; i < s.len(); i++)
      msgQ.push_back((s[i] == "|") ? SOH : 8'(s[i]));
  endtask

  // Finds the first <SOH>10= in the message, sums everything through that
  // SOH, then parses up to three digits and the terminator.
  task automatic model_msg(output int idx, output logic [1:0] err,
                           output logic [7:0] calc, output logic [9:0] rcv);
    int pos, s, v, n;
    idx = -1; err = 2'b00; calc = 8'd0; rcv = 10'd0;
    pos = -1; n = msgQ.size();
    for (int i = 0; i + 3 < n; i++) begin
      if (pos < 0 && msgQ[i] == SOH && msgQ[i+1] == "1" && msgQ[i+2] == "0" && msgQ[i+3] == "=")
        pos = i;
    end
    if (pos < 0) return;
    s = 0;
    for (int j = 0; j <= pos; j++) s += msgQ[j];
    calc = 8'(s % 256);
    v = 0;
    for (int k = 0; k < 3; k++) begin
      if (pos + 4 + k >= n) return;
      if (msgQ[pos+4+k] < "0" || msgQ[pos+4+k] > "9") begin
        idx = pos + 4 + k; err = 2'b10; rcv = 10'(v);
        return;
      end
      v = v * 10 + (msgQ[pos+4+k] - 48);
    end
    if (pos + 7 >= n) return;
    idx = pos + 7; rcv = 10'(v);
    if (msgQ[pos+7] != SOH) err = 2'b10;
    else err = (v == (s % 256)) ? 2'b00 : 2'b01;
  endtask

  task automatic run_msg(input string name, input int expIdx, input logic [1:0] eErr,
                         input logic [7:0] eCalc, input logic [9:0] eRcv, input bit gaps);
    for (int i = 0; i < msgQ.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          drive_idle();
          checks++;
          if (done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s gap done: got %0b want 0", name, done_o);
          end
        end
      end
      drive_byte(msgQ[i], i == 0);
      checks++;
      if (done_o !== (i == expIdx)) begin
        errors++;
        $display("[TB] FAIL %s done@%0d: got %0b want %0b", name, i, done_o, i == expIdx);
      end
      if (i == expIdx) begin
        checks++;
        if (err_code_o !== eErr || calc_checksum_o !== eCalc || rcv_value_o !== eRcv) begin
          errors++;
          $display("[TB] FAIL %s verdict: got err=%b calc=%0d rcv=%0d want err=%b calc=%0d rcv=%0d",
                   name, err_code_o, calc_checksum_o, rcv_value_o, eErr, eCalc, eRcv);
        end
      end
    end
    drive_idle();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s pulse width: got done=%0b want 0", name, done_o);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (done_o !== 1'b0 || err_code_o !== 2'b00 || calc_checksum_o !== 8'd0 || rcv_value_o !== 10'd0) begin
      errors++;
      $display("[TB] FAIL %s zero: got done=%0b err=%b calc=%0d rcv=%0d want all 0",
               name, done_o, err_code_o, calc_checksum_o, rcv_value_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_zero("reset");
  endtask

  task automatic test_match();
    load_str("8=A|10=183|"); run_msg("match", 10, 2'b00, 8'd183, 10'd183, 1'b0);
  endtask

  task automatic test_mismatch();
    load_str("8=A|10=184|"); run_msg("mismatch184", 10, 2'b01, 8'd183, 10'd184, 1'b0);
    load_str("8=A|10=300|"); run_msg("mismatch300", 10, 2'b01, 8'd183, 10'd300, 1'b0);
  endtask

  task automatic test_false_tag();
    load_str("8=A|11=5|10=140|"); run_msg("false_tag", 15, 2'b00, 8'd140, 10'd140, 1'b0);
  endtask

  task automatic test_gaps();
    load_str("8=A|10=183|"); run_msg("gaps", 10, 2'b00, 8'd183, 10'd183, 1'b1);
  endtask

  task automatic test_format();
    load_str("8=A|10=1A3|"); run_msg("format_digit", 8, 2'b10, 8'd183, 10'd1, 1'b0);
    load_str("8=A|10=183X"); run_msg("format_term", 10, 2'b10, 8'd183, 10'd183, 1'b0);
  endtask

  task automatic test_abort();
    do_reset();
    load_str("8=A"); run_msg("abort_msg1", -1, 2'b00, 8'd0, 10'd0, 1'b0);
    load_str("8=A|10=183|");
    drive_byte(msgQ[0], 1'b1);
    checks++;
    if (done_o !== 1'b1 || err_code_o !== 2'b11 || calc_checksum_o !== 8'd0 || rcv_value_o !== 10'd0) begin
      errors++;
      $display("[TB] FAIL abort verdict: got done=%0b err=%b calc=%0d rcv=%0d want 1 11 0 0",
               done_o, err_code_o, calc_checksum_o, rcv_value_o);
    end
    for (int i = 1; i < msgQ.size(); i++) begin
      drive_byte(msgQ[i], 1'b0);
      checks++;
      if (done_o !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL abort_msg2 done@%0d: got %0b want %0b", i, done_o, i == 10);
      end
    end
    checks++;
    if (err_code_o !== 2'b00 || calc_checksum_o !== 8'd183 || rcv_value_o !== 10'd183) begin
      errors++;
      $display("[TB] FAIL abort_msg2 verdict: got err=%b calc=%0d rcv=%0d want 00 183 183",
               err_code_o, calc_checksum_o, rcv_value_o);
    end
  endtask

  task automatic test_reset_mid();
    load_str("8=A|10=1");
    for (int i = 0; i < msgQ.size(); i++) drive_byte(msgQ[i], i == 0);
    rst = 1'b1;
    drive_byte("8", 1'b1);
    rst = 1'b0;
    check_zero("reset_mid");
    load_str("8=A|10=183|");
    for (int i = 0; i < msgQ.size(); i++) begin
      drive_byte(msgQ[i], 1'b0);
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid nosop done@%0d: got %0b want 0", i, done_o);
      end
    end
    check_zero("reset_mid_after");
  endtask

  task automatic test_random();
    int s, v, idx, kind, pos;
    logic [1:0] eErr;
    logic [7:0] eCalc, b;
    logic [9:0] eRcv;
    for (int m = 0; m < 40; m++) begin
      msgQ.delete();
      msgQ.push_back("8"); msgQ.push_back("=");
      repeat ($urandom_range(1, 10)) begin
        case ($urandom_range(0, 5))
          0: b = SOH;
          1: b = "1";
          2: b = "0";
          3: b = 8'h3D;
          default: b = 8'($urandom);
        endcase
        msgQ.push_back(b);
      end
      msgQ.push_back(SOH); msgQ.push_back("1"); msgQ.push_back("0"); msgQ.push_back("=");
      s = 0;
      for (int j = 0; j < msgQ.size() - 3; j++) s += msgQ[j];
      s = s % 256;
      kind = $urandom_range(0, 3);
      v = (kind == 1) ? $urandom_range(0, 999) : s;
      msgQ.push_back(8'(48 + v / 100));
      msgQ.push_back(8'(48 + (v / 10) % 10));
      msgQ.push_back(8'(48 + v % 10));
      msgQ.push_back((kind == 3) ? 8'(65 + $urandom_range(0, 25)) : SOH);
      if (kind == 2) begin
        pos = msgQ.size() - 4 + $urandom_range(0, 2);
        msgQ[pos] = 8'(65 + $urandom_range(0, 25));
      end
      model_msg(idx, eErr, eCalc, eRcv);
      run_msg($sformatf("random%0d", m), idx, eErr, eCalc, eRcv, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; data_i = 8'h00;
    test_reset();
    test_match();
    test_mismatch();
    test_false_tag();
    test_gaps();
    test_format();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_checksum_check.md
# fix_checksum_check

Receive-side FIX checksum verifier. It sits in the inbound byte path next to the tag parser. It accumulates the mod-256 byte sum of each incoming FIX message, finds the trailing `<SOH>10=` checksum field, and converts its three ASCII digits to binary. It then reports one verdict per message: match, mismatch, malformed trailer, or aborted. It is the receive counterpart of the transmit-side checksum generator, which emits the three ASCII digits.

## Interface
Parameters: none. Field tag `10`, `SOH` = 8'h01 and `=` = 8'h3D are fixed constants.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- data_i  input  8  incoming message byte.
- valid_i  input  1  data_i is valid this cycle; byte ignored when low.
- sop_i  input  1  qualified by valid_i; data_i is the first byte of a new message (the `8` of `8=`).
- done_o  output  1  one-cycle pulse: verdict valid.
- err_code_o  output  2  valid with done_o. 2'b00 OK, 2'b01 MISMATCH, 2'b10 FORMAT, 2'b11 ABORT.
- calc_checksum_o  output  8  computed sum mod 256; held until the next done_o.
- rcv_value_o  output  10  decimal value parsed from the trailer (0..999); held until the next done_o.

## Operation
- Accepted byte: a byte with valid_i=1. When valid_i=0 the state and all registers hold.
- Running sum `sum`: 8-bit and wraps naturally. sop_i loads `sum` with data_i; each body byte adds data_i. `snap` is an 8-bit copy of `sum` taken after adding each SOH byte.
- Checksum covers every byte up to and including the SOH that precedes `10=`. `snap` is the value compared.
- States:
  - IDLE: bytes without sop_i are ignored. sop_i goes to BODY, or to T1 if the byte is SOH.
  - BODY: add byte. SOH goes to T1 (update snap); any other byte stays in BODY.
  - T1: add byte. `1` goes to T0. SOH stays in T1 (update snap). Any other byte goes to BODY.
  - T0: add byte. `0` goes to TEQ. SOH goes to T1 (update snap). Any other byte goes to BODY. Bytes are always summed in these states because a false tag match belongs to the body.
  - TEQ: add byte. `=` goes to D0 and clears the accumulator `acc`. SOH goes to T1 (update snap). Any other byte goes to BODY.
  - D0, D1, D2: byte must be ASCII `0`..`9`. Then `acc <= acc*10 + (byte-8'h30)`, with *10 built as (acc<<3)+(acc<<1) at 10-bit width, and move to the next state (D2 goes to TERM). A non-digit is a FORMAT verdict; go to IDLE.
  - TERM: byte must be SOH. If `acc == {2'b00, snap}`, the verdict is OK; otherwise MISMATCH. Any value above 255 is always MISMATCH. A non-SOH byte gives FORMAT. Go to IDLE.
- Trailer bytes (digits, SOH terminator) are never added to `sum`.
- sop_i accepted in any state other than IDLE gives an ABORT verdict for the old message. The same byte starts the new message, with sum loaded from data_i.
- The verdict registers calc_checksum_o = snap and rcv_value_o = acc. For a FORMAT verdict, rcv_value_o holds the partial acc.

## Timing
- Reset: state IDLE; done_o=0, err_code_o=0, calc_checksum_o=0, rcv_value_o=0; sum, snap and acc are 0.
- Latency: done_o, err_code_o, calc_checksum_o and rcv_value_o update on the clock edge that accepts the deciding byte, so they are visible the cycle after it. done_o is high for exactly one cycle.
- Throughput: one byte per cycle, with no stall output. A new sop_i is accepted in the cycle right after the terminating SOH.
- rst mid-message: the message is discarded, there is no done_o pulse, and outputs return to their reset values.
- ABORT and a new message start happen in the same cycle. The next verdict refers to the new message.

## Test plan
- `8=A<SOH>10=183<SOH>` sent back-to-back with sop_i on `8` gives done_o one cycle after the last SOH, err=00, calc=183, rcv=183.
- Same message with trailer `10=184` gives err=01, calc=183, rcv=184. Trailer `10=300` gives err=01, rcv=300.
- False tag `8=A<SOH>11=5<SOH>10=140<SOH>` gives err=00, calc=140. Also repeat the first message with random valid_i gaps: the result is identical.
- Trailer `10=1A3` gives err=10 one cycle after `A`, with no further pulse. Trailer `10=183X` gives err=10 after `X`.
- sop_i asserted in BODY of message 1 gives err=11 pulse. Message 2 (`8=A<SOH>10=183<SOH>`) then gives err=00.
- rst asserted during D1 gives no done_o and all outputs 0. Bytes without sop_i are ignored afterward.
